change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Sequential inverse of the coin-value mux. Takes an 8-bit change amount and breaks it into a sequence of coin codes, largest coin first.
- Coin code encoding: 00=5, 01=10, 10=25, 11=100.
- Offers one coin at a time to the payout mechanism over a valid/ack handshake, then reports completion, residue and errors.
- Sits between the vending controller's change calculation and the coin-tube drivers.

Parameters:
ACK_TIMEOUT, 255, max cycles COIN_VALID may wait for COIN_ACK before abort; 1..255.
MAX_COINS, 15, max coins per transaction before abort; 1..15.

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  request payout of AMOUNT; honoured only in IDLE
AMOUNT  input  8  change to pay, sampled on accepted START
COIN_ACK  input  1  payout mechanism took the offered coin
COIN_VALID  output  1  coin offer pending
COIN_SEL  output  2  coin code offered (00=5, 01=10, 10=25, 11=100)
BUSY  output  1  transaction in progress
DONE  output  1  one-cycle completion pulse
ERR  output  1  residue, timeout or coin limit; valid with DONE, held until next START
TIMEOUT  output  1  abort cause was ACK timeout; held until next START
REMAIN  output  8  amount still owed
COIN_CNT  output  4  coins dispensed this transaction

Behaviour:
- Reset (async, RST_N low): all outputs 0, FSM to IDLE, timeout counter 0. Takes effect immediately, including mid-offer.
- FSM states: IDLE, SELECT, OFFER, FINISH.
- IDLE: BUSY=0.
  - START=1 → REMAIN<=AMOUNT, COIN_CNT<=0, ERR<=0, TIMEOUT<=0, BUSY<=1, go to SELECT.
  - START outside IDLE is ignored.
- SELECT: greedy choice on REMAIN: >=100 → 11; else >=25 → 10; else >=10 → 01; else >=5 → 00.
  - REMAIN<5 → go to FINISH.
  - COIN_CNT==MAX_COINS with REMAIN>=5 → ERR<=1, go to FINISH.
  - Otherwise COIN_SEL<=code, COIN_VALID<=1, clear timeout counter, go to OFFER.
- OFFER: COIN_VALID and COIN_SEL held stable.
  - COIN_ACK=1 on a clock edge → REMAIN<=REMAIN−value, COIN_CNT+1, COIN_VALID<=0, go to SELECT.
  - Otherwise timeout counter +1.
  - Counter reaches ACK_TIMEOUT → COIN_VALID<=0, ERR<=1, TIMEOUT<=1, REMAIN unchanged, go to FINISH.
  - COIN_ACK outside OFFER is ignored.
- FINISH: DONE=1 for exactly one cycle; ERR<=1 if REMAIN!=0; BUSY<=0; go to IDLE.
- Latency:
  - START edge → first COIN_VALID two edges later.
  - COIN_ACK edge → next COIN_VALID two edges later.
  - Last ACK → DONE two edges later.
- Arithmetic: 8-bit unsigned; the subtraction never underflows because the greedy choice guarantees value<=REMAIN.
- AMOUNT=0: no coin offered; DONE with ERR=0.
- Non-multiple-of-5 amount: pays down to residue 1..4; REMAIN=residue; ERR=1.
- AMOUNT=255: 100,100,25,25,5 then ERR=0.

Optional Feature:
CHANGE_INVENTORY_EN:
- Defined: adds input EMPTY[3:0]; bit n=1 means coin code n's tube is empty.
  - SELECT skips empty denominations and takes the next smaller stocked coin that fits.
  - If no stocked coin fits while REMAIN>=5 → ERR, go to FINISH.
  - EMPTY is sampled in SELECT only.
- Undefined: no EMPTY port; all tubes treated as stocked.

Test Plan:
1. AMOUNT=140, COIN_ACK tied high → COIN_SEL sequence 11,10,01,00; DONE, ERR=0, REMAIN=0, COIN_CNT=4.
2. AMOUNT=0 → COIN_VALID never asserted; DONE pulse 2 edges after START; ERR=0.
3. AMOUNT=37 with prompt acks → coins 10,01; DONE, ERR=1, REMAIN=2, COIN_CNT=2.
4. AMOUNT=30, COIN_ACK low 10 cycles, extra START pulses during wait → COIN_VALID=1 and COIN_SEL=10 stable; STARTs ignored; after ack: coin 00, DONE, ERR=0.
5. ACK_TIMEOUT=8, AMOUNT=5, never ack → COIN_VALID drops after 8 cycles; DONE, ERR=1, TIMEOUT=1, REMAIN=5. Then RST_N low mid-OFFER of a new transaction → all outputs 0 asynchronously; with CHANGE_INVENTORY_EN, AMOUNT=100 and EMPTY=4'b1000 → four 10 coins.
6. MAX_COINS=2, AMOUNT=15 (CHANGE_INVENTORY_EN, EMPTY=4'b0010) → coins 00,00; DONE, ERR=1, REMAIN=5.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Handshake/status bundle between the change calculation, the dispenser and the coin-tube drivers.
// Optional macro CHANGE_INVENTORY_EN adds the per-denomination EMPTY flags.
interface change_dispenser_if;
  logic       START;
  logic [7:0] AMOUNT;
  logic       COIN_ACK;
`ifdef CHANGE_INVENTORY_EN
  logic [3:0] EMPTY;
`endif
  logic       COIN_VALID;
  logic [1:0] COIN_SEL;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic       TIMEOUT;
  logic [7:0] REMAIN;
  logic [3:0] COIN_CNT;

`ifdef CHANGE_INVENTORY_EN
  modport master (
    output START, AMOUNT, COIN_ACK, EMPTY,
    input  COIN_VALID, COIN_SEL, BUSY, DONE, ERR, TIMEOUT, REMAIN, COIN_CNT
  );
  modport slave (
    input  START, AMOUNT, COIN_ACK, EMPTY,
    output COIN_VALID, COIN_SEL, BUSY, DONE, ERR, TIMEOUT, REMAIN, COIN_CNT
  );
`else
  modport master (
    output START, AMOUNT, COIN_ACK,
    input  COIN_VALID, COIN_SEL, BUSY, DONE, ERR, TIMEOUT, REMAIN, COIN_CNT
  );
  modport slave (
    input  START, AMOUNT, COIN_ACK,
    output COIN_VALID, COIN_SEL, BUSY, DONE, ERR, TIMEOUT, REMAIN, COIN_CNT
  );
`endif
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: splits AMOUNT into coins (100/25/10/5), offering one per valid/ack handshake.
// Optional macro CHANGE_INVENTORY_EN: honours EMPTY tube flags when choosing coins.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned MAX_COINS   = 15
) (
  input logic               CLK,
  input logic               RST_N,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER,
    FINISH
  } state_t;

  localparam logic [7:0] ACK_LIMIT  = 8'(ACK_TIMEOUT);
  localparam logic [3:0] COIN_LIMIT = 4'(MAX_COINS);

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      2'b00:   v = 8'd5;
      2'b01:   v = 8'd10;
      2'b10:   v = 8'd25;
      default: v = 8'd100;
    endcase
    return v;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [3:0] coin_cnt_q, coin_cnt_d;
  logic [1:0] coin_sel_q, coin_sel_d;
  logic       coin_valid_q, coin_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       timeout_q, timeout_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic [3:0] stocked;
  logic       pick_ok;
  logic [1:0] pick_code;
  logic [7:0] tmo_next;

`ifdef CHANGE_INVENTORY_EN
  assign stocked = ~bus.EMPTY;
`else
  assign stocked = '1;
`endif

  // Priority chain naturally falls through to the next smaller stocked coin that fits.
  always_comb begin
    pick_ok   = 1'b0;
    pick_code = '0;
    if (stocked[3] && remain_q >= 8'd100) begin
      pick_ok   = 1'b1;
      pick_code = 2'b11;
    end else if (stocked[2] && remain_q >= 8'd25) begin
      pick_ok   = 1'b1;
      pick_code = 2'b10;
    end else if (stocked[1] && remain_q >= 8'd10) begin
      pick_ok   = 1'b1;
      pick_code = 2'b01;
    end else if (stocked[0] && remain_q >= 8'd5) begin
      pick_ok   = 1'b1;
      pick_code = 2'b00;
    end
  end

  assign tmo_next = tmo_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    coin_cnt_d   = coin_cnt_q;
    coin_sel_d   = coin_sel_q;
    coin_valid_d = coin_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    timeout_d    = timeout_q;
    tmo_cnt_d    = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.START) begin
          remain_d   = bus.AMOUNT;
          coin_cnt_d = '0;
          err_d      = 1'b0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = SELECT;
        end
      end

      // Residue error is folded in on the way into FINISH so ERR is valid alongside DONE.
      SELECT: begin
        if (remain_q < 8'd5) begin
          err_d   = err_q | (remain_q != 8'd0);
          done_d  = 1'b1;
          state_d = FINISH;
        end else if (coin_cnt_q == COIN_LIMIT || !pick_ok) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          coin_sel_d   = pick_code;
          coin_valid_d = 1'b1;
          tmo_cnt_d    = '0;
          state_d      = OFFER;
        end
      end

      OFFER: begin
        if (bus.COIN_ACK) begin
          remain_d     = remain_q - coin_value(coin_sel_q);
          coin_cnt_d   = coin_cnt_q + 4'd1;
          coin_valid_d = 1'b0;
          state_d      = SELECT;
        end else begin
          tmo_cnt_d = tmo_next;
          if (tmo_next == ACK_LIMIT) begin
            coin_valid_d = 1'b0;
            err_d        = 1'b1;
            timeout_d    = 1'b1;
            done_d       = 1'b1;
            state_d      = FINISH;
          end
        end
      end

      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      remain_q     <= '0;
      coin_cnt_q   <= '0;
      coin_sel_q   <= '0;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      remain_q     <= remain_d;
      coin_cnt_q   <= coin_cnt_d;
      coin_sel_q   <= coin_sel_d;
      coin_valid_q <= coin_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.COIN_VALID = coin_valid_q;
  assign bus.COIN_SEL   = coin_sel_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.TIMEOUT    = timeout_q;
  assign bus.REMAIN     = remain_q;
  assign bus.COIN_CNT   = coin_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: three dispensers (default, short ack timeout, two-coin limit) share one stimulus.
module tb_change_dispenser;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] amount;
  logic       coin_ack;
  logic [3:0] empty;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  change_dispenser_if if_a ();
  change_dispenser_if if_b ();
  change_dispenser_if if_c ();

  assign if_a.START = start;  assign if_a.AMOUNT = amount;  assign if_a.COIN_ACK = coin_ack;
  assign if_b.START = start;  assign if_b.AMOUNT = amount;  assign if_b.COIN_ACK = coin_ack;
  assign if_c.START = start;  assign if_c.AMOUNT = amount;  assign if_c.COIN_ACK = coin_ack;
`ifdef CHANGE_INVENTORY_EN
  assign if_a.EMPTY = empty;
  assign if_b.EMPTY = empty;
  assign if_c.EMPTY = empty;
`endif

  change_dispenser #(.ACK_TIMEOUT(255), .MAX_COINS(15)) u_a (.CLK(CLK), .RST_N(rst_n), .bus(if_a.slave));
  change_dispenser #(.ACK_TIMEOUT(8),   .MAX_COINS(15)) u_b (.CLK(CLK), .RST_N(rst_n), .bus(if_b.slave));
  change_dispenser #(.ACK_TIMEOUT(255), .MAX_COINS(2))  u_c (.CLK(CLK), .RST_N(rst_n), .bus(if_c.slave));

  logic [2:0] done_v;
  assign done_v = {if_c.DONE, if_b.DONE, if_a.DONE};

  logic [1:0] coins_a[$];
  logic [1:0] coins_b[$];
  logic [1:0] coins_c[$];

  always @(posedge CLK) begin
    if (if_a.COIN_VALID && if_a.COIN_ACK) coins_a.push_back(if_a.COIN_SEL);
    if (if_b.COIN_VALID && if_b.COIN_ACK) coins_b.push_back(if_b.COIN_SEL);
    if (if_c.COIN_VALID && if_c.COIN_ACK) coins_c.push_back(if_c.COIN_SEL);
  end

  function automatic logic [19:0] pack_q(input logic [1:0] q[$]);
    logic [19:0] r;
    r = '0;
    foreach (q[i]) r = {r[17:0], q[i]};
    return r;
  endfunction

  task automatic apply_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    amount   = '0;
    coin_ack = 1'b0;
    empty    = '0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    coins_a.delete();
    coins_b.delete();
    coins_c.delete();
  endtask

  task automatic wait_done(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done_v[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    coin_ack = 1'b0;
    @(negedge CLK);
    tests_run++;
    if ({if_a.COIN_VALID, if_a.COIN_SEL, if_a.BUSY, if_a.DONE, if_a.ERR, if_a.TIMEOUT,
         if_a.REMAIN, if_a.COIN_CNT} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b sel=%b busy=%b done=%b err=%b to=%b rem=%0d cnt=%0d, want all 0",
               if_a.COIN_VALID, if_a.COIN_SEL, if_a.BUSY, if_a.DONE, if_a.ERR, if_a.TIMEOUT,
               if_a.REMAIN, if_a.COIN_CNT);
    end
    apply_reset();
  endtask

  task automatic test_greedy();
    bit ok;
    apply_reset();
    coin_ack = 1'b1;
    @(negedge CLK); start = 1'b1; amount = 8'd140;
    @(negedge CLK); start = 1'b0;
    tests_run++;
    if (if_a.COIN_VALID !== 1'b0 || if_a.BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL greedy_first_edge: valid=%b busy=%b, want valid=0 busy=1", if_a.COIN_VALID, if_a.BUSY);
    end
    @(negedge CLK);
    tests_run++;
    if (if_a.COIN_VALID !== 1'b1 || if_a.COIN_SEL !== 2'b11) begin
      tests_failed++;
      $display("FAIL greedy_first_offer: valid=%b sel=%b, want 1/11", if_a.COIN_VALID, if_a.COIN_SEL);
    end
    wait_done(0, 40, ok);
    tests_run++;
    if (!ok || if_a.ERR !== 1'b0 || if_a.REMAIN !== 8'd0 || if_a.COIN_CNT !== 4'd4) begin
      tests_failed++;
      $display("FAIL greedy_140_done: done=%b err=%b rem=%0d cnt=%0d, want 1/0/0/4", ok, if_a.ERR, if_a.REMAIN, if_a.COIN_CNT);
    end
    tests_run++;
    if (coins_a.size() != 4 || pack_q(coins_a) !== 20'h000E4) begin
      tests_failed++;
      $display("FAIL greedy_140_coins: n=%0d packed=%h, want n=4 packed=000e4", coins_a.size(), pack_q(coins_a));
    end
    @(negedge CLK);
    tests_run++;
    if (if_a.DONE !== 1'b0 || if_a.BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_one_cycle: done=%b busy=%b, want 0/0", if_a.DONE, if_a.BUSY);
    end

    coins_a.delete();
    @(negedge CLK); start = 1'b1; amount = 8'd255;
    @(negedge CLK); start = 1'b0;
    wait_done(0, 40, ok);
    tests_run++;
    if (!ok || if_a.ERR !== 1'b0 || if_a.REMAIN !== 8'd0 || coins_a.size() != 5 ||
        pack_q(coins_a) !== 20'h003E8) begin
      tests_failed++;
      $display("FAIL greedy_255: done=%b err=%b rem=%0d n=%0d packed=%h, want 1/0/0/5/003e8",
               ok, if_a.ERR, if_a.REMAIN, coins_a.size(), pack_q(coins_a));
    end
  endtask

  task automatic test_zero_amount();
    bit seen_valid;
    apply_reset();
    coin_ack = 1'b1;
    seen_valid = 1'b0;
    @(negedge CLK); start = 1'b1; amount = 8'd0;
    @(negedge CLK); start = 1'b0;
    seen_valid |= if_a.COIN_VALID;
    tests_run++;
    if (if_a.DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_early_done: done=%b, want 0", if_a.DONE);
    end
    @(negedge CLK);
    seen_valid |= if_a.COIN_VALID;
    tests_run++;
    if (if_a.DONE !== 1'b1 || if_a.ERR !== 1'b0 || if_a.COIN_CNT !== 4'd0) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b err=%b cnt=%0d, want 1/0/0", if_a.DONE, if_a.ERR, if_a.COIN_CNT);
    end
    @(negedge CLK);
    seen_valid |= if_a.COIN_VALID;
    tests_run++;
    if (seen_valid !== 1'b0 || if_a.BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_no_coin: valid_seen=%b busy=%b, want 0/0", seen_valid, if_a.BUSY);
    end
  endtask

  task automatic test_residue();
    bit ok;
    apply_reset();
    coin_ack = 1'b1;
    @(negedge CLK); start = 1'b1; amount = 8'd37;
    @(negedge CLK); start = 1'b0;
    wait_done(0, 40, ok);
    tests_run++;
    if (!ok || if_a.ERR !== 1'b1 || if_a.REMAIN !== 8'd2 || if_a.COIN_CNT !== 4'd2 ||
        coins_a.size() != 2 || pack_q(coins_a) !== 20'h00009) begin
      tests_failed++;
      $display("FAIL residue_37: done=%b err=%b rem=%0d cnt=%0d n=%0d packed=%h, want 1/1/2/2/2/00009",
               ok, if_a.ERR, if_a.REMAIN, if_a.COIN_CNT, coins_a.size(), pack_q(coins_a));
    end
    tests_run++;
    if (if_a.TIMEOUT !== 1'b0) begin
      tests_failed++;
      $display("FAIL residue_timeout_flag: got %b want 0", if_a.TIMEOUT);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stable;
    apply_reset();
    @(negedge CLK); start = 1'b1; amount = 8'd30;
    @(negedge CLK); start = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      start  = (k % 3 == 1);
      amount = 8'd200;
      @(negedge CLK);
      if (if_a.COIN_VALID !== 1'b1 || if_a.COIN_SEL !== 2'b10 || if_a.BUSY !== 1'b1) stable = 1'b0;
    end
    start = 1'b0;
    tests_run++;
    if (stable !== 1'b1 || if_a.REMAIN !== 8'd30) begin
      tests_failed++;
      $display("FAIL stall_hold: stable=%b rem=%0d, want 1/30", stable, if_a.REMAIN);
    end
    coin_ack = 1'b1;
    wait_done(0, 20, ok);
    tests_run++;
    if (!ok || if_a.ERR !== 1'b0 || if_a.REMAIN !== 8'd0 || if_a.COIN_CNT !== 4'd2 ||
        coins_a.size() != 2 || pack_q(coins_a) !== 20'h00008) begin
      tests_failed++;
      $display("FAIL stall_finish: done=%b err=%b rem=%0d cnt=%0d n=%0d packed=%h, want 1/0/0/2/2/00008",
               ok, if_a.ERR, if_a.REMAIN, if_a.COIN_CNT, coins_a.size(), pack_q(coins_a));
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    @(negedge CLK); start = 1'b1; amount = 8'd5;
    @(negedge CLK); start = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (if_b.COIN_VALID) n++;
      else if (n > 0) break;
    end
    tests_run++;
    if (n != 8) begin
      tests_failed++;
      $display("FAIL timeout_cycles: valid held %0d cycles, want 8", n);
    end
    tests_run++;
    if (if_b.DONE !== 1'b1 || if_b.ERR !== 1'b1 || if_b.TIMEOUT !== 1'b1 || if_b.REMAIN !== 8'd5 ||
        if_b.COIN_CNT !== 4'd0) begin
      tests_failed++;
      $display("FAIL timeout_status: done=%b err=%b to=%b rem=%0d cnt=%0d, want 1/1/1/5/0",
               if_b.DONE, if_b.ERR, if_b.TIMEOUT, if_b.REMAIN, if_b.COIN_CNT);
    end
    @(negedge CLK);
    tests_run++;
    if (if_b.DONE !== 1'b0 || if_b.TIMEOUT !== 1'b1 || if_b.ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_held: done=%b to=%b err=%b, want 0/1/1", if_b.DONE, if_b.TIMEOUT, if_b.ERR);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    @(negedge CLK); start = 1'b1; amount = 8'd100;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (if_a.COIN_VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_precondition: valid=%b, want 1", if_a.COIN_VALID);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({if_a.COIN_VALID, if_a.COIN_SEL, if_a.BUSY, if_a.DONE, if_a.ERR, if_a.TIMEOUT,
         if_a.REMAIN, if_a.COIN_CNT} !== 21'd0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b sel=%b busy=%b rem=%0d, want all 0",
               if_a.COIN_VALID, if_a.COIN_SEL, if_a.BUSY, if_a.REMAIN);
    end
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic test_inventory();
    bit ok;
    apply_reset();
    empty = 4'b1000;
    coin_ack = 1'b1;
    @(negedge CLK); start = 1'b1; amount = 8'd100;
    @(negedge CLK); start = 1'b0;
    wait_done(0, 40, ok);
    tests_run++;
    if (!ok || if_a.ERR !== 1'b0 || if_a.REMAIN !== 8'd0 || coins_a.size() != 4 ||
        pack_q(coins_a) !== 20'h000AA) begin
      tests_failed++;
      $display("FAIL inventory_skip: done=%b err=%b rem=%0d n=%0d packed=%h, want 1/0/0/4/000aa",
               ok, if_a.ERR, if_a.REMAIN, coins_a.size(), pack_q(coins_a));
    end
  endtask
`endif

  task automatic test_coin_limit();
    bit ok;
    logic [19:0] exp_pack;
    apply_reset();
    coin_ack = 1'b1;
`ifdef CHANGE_INVENTORY_EN
    empty = 4'b0010;
    amount = 8'd15;
    exp_pack = 20'h00000;
`else
    amount = 8'd40;
    exp_pack = 20'h00009;
`endif
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    wait_done(2, 40, ok);
    tests_run++;
    if (!ok || if_c.ERR !== 1'b1 || if_c.REMAIN !== 8'd5 || if_c.COIN_CNT !== 4'd2 ||
        coins_c.size() != 2 || pack_q(coins_c) !== exp_pack) begin
      tests_failed++;
      $display("FAIL coin_limit: done=%b err=%b rem=%0d cnt=%0d n=%0d packed=%h, want 1/1/5/2/2/%h",
               ok, if_c.ERR, if_c.REMAIN, if_c.COIN_CNT, coins_c.size(), pack_q(coins_c), exp_pack);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    amount = '0;
    coin_ack = 1'b0;
    empty = '0;
    test_reset();
    test_greedy();
    test_zero_amount();
    test_residue();
    test_stall();
    test_timeout();
    test_async_reset();
`ifdef CHANGE_INVENTORY_EN
    test_inventory();
`endif
    test_coin_limit();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
